stream_mem_loader: RTL
======================

// Module: stream_mem_loader
// PURPOSE
//  Upstream boot loader for top. Takes a byte stream (valid/ready) carrying a
//  16-bit word count and then the program/data words. Drives top's
//  com_data_in/com_addr/com_wr_en memory-write port, then switches status to
//  RUN and times execution until top raises end_process.
// PARAMETERS
//  BASE_ADDR  16'd0       first memory address written
//  MAX_WORDS  17'd65536   largest legal word count; a larger header is an error
//  TIMEOUT    32'd1000000 RUN cycles allowed before err_timeout (0 = no timeout)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  rx_data      in   8   stream byte
//  rx_valid     in   1   rx_data valid
//  rx_ready     out  1   loader accepts a byte when rx_valid & rx_ready
//  com_data_in  out  16  write data to top
//  com_addr     out  16  write address to top
//  com_wr_en    out  1   one-cycle write strobe to top
//  status       out  2   2'b00 = load/hold, 2'b01 = run (to top)
//  end_process  in   1   from top, program finished
//  busy         out  1   high in HDR/DATA/WRITE/RUN states
//  run_done     out  1   sticky, end_process seen
//  err_len      out  1   sticky, header count > MAX_WORDS
//  err_timeout  out  1   sticky, RUN exceeded TIMEOUT
//  run_cycles   out  32  cycles spent in RUN, frozen on exit
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE. All outputs are 0 during
//    reset, including status=00, rx_ready=0, com_addr=0 and com_wr_en=0.
//  - States: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, RUN, DONE, ERR.
//  - IDLE: rx_ready=0 for one cycle after reset release, then go to HDR_HI.
//  - rx_ready=1 only in HDR_HI, HDR_LO, DAT_HI and DAT_LO. Bytes arrive high
//    byte first. The state advances only on an accepted byte.
//  - HDR_LO accept: N = {hi, lo}.
//      N > MAX_WORDS: go to ERR and set err_len.
//      N == 0: go straight to RUN.
//      Otherwise go to DAT_HI. Set idx = 0 and com_addr = BASE_ADDR.
//  - DAT_LO accept: latch com_data_in = {hi, lo} and go to WRITE.
//  - WRITE lasts exactly 1 cycle.
//      com_wr_en=1 and rx_ready=0.
//      com_addr = BASE_ADDR + idx, computed mod 2^16 (wraps from 16'hFFFF to 0).
//      Next cycle: com_wr_en=0 and idx increments.
//      If idx+1 == N, go to RUN; else go to DAT_HI.
//  - Latency: the write strobe asserts 1 cycle after the low byte is accepted.
//    Peak rate is 1 word per 3 cycles.
//  - com_data_in and com_addr hold their last values outside WRITE.
//  - RUN:
//      status=01, from the cycle after the final WRITE (or after HDR_LO when N=0).
//      run_cycles increments each cycle, saturating at 32'hFFFFFFFF.
//      end_process=1: go to DONE and set run_done. The run_cycles increment
//      in that cycle still counts.
//      TIMEOUT!=0 and run_cycles == TIMEOUT-1 with end_process=0: go to ERR
//      and set err_timeout.
//      If end_process and the timeout hit in the same cycle, end_process wins.
//  - DONE and ERR: terminal.
//      rx_ready=0 and com_wr_en=0. run_cycles is frozen.
//      DONE holds status=01. ERR drives status=00.
//      The only exit is rst_n.
//  - end_process outside RUN is ignored.
//  - rx_valid while rx_ready=0: the byte is not consumed and the source holds it.
//  - Reset mid-load or mid-run aborts immediately. Memory already written is
//    not cleared, and the next stream restarts at the header.
// TESTING
//  1. Header 0x0003, words 0x1234, 0xABCD, 0x0001 -> com_wr_en pulses at
//     addr 0, 1, 2 with that data, each exactly 1 cycle after its low byte;
//     status=01 on the cycle after the third write.
//  2. Same stream with rx_valid gapped at random -> identical writes, and
//     rx_ready=0 in every WRITE cycle.
//  3. Header 0x0000 -> no com_wr_en; status=01 one cycle after HDR_LO; raise
//     end_process 10 cycles later -> run_done=1, run_cycles=10, status stays 01.
//  4. BASE_ADDR=16'hFFFE, N=3 -> writes at FFFE, FFFF, 0000.
//  5. MAX_WORDS=4, header 0x0005 -> err_len=1, no writes, rx_ready=0 from then.
//  6. TIMEOUT=8, N=1, end_process never raised -> err_timeout=1 with
//     run_cycles=8 and status=00. Then assert rst_n=0 mid-RUN in a second run
//     -> all outputs return to 0 in the same cycle (asynchronous).

Source files
------------

// File: rtl/stream_mem_loader.sv
// Boot loader: takes a byte stream (16-bit word count, then words) and writes the words into
// top's memory port, then raises status=RUN and counts cycles until end_process or timeout.
module stream_mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter logic [16:0] MAX_WORDS = 17'd65536,
  parameter logic [31:0] TIMEOUT   = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] com_data_in,
  output logic [15:0] com_addr,
  output logic        com_wr_en,
  output logic [1:0]  status,
  input  logic        end_process,
  output logic        busy,
  output logic        run_done,
  output logic        err_len,
  output logic        err_timeout,
  output logic [31:0] run_cycles
);
  localparam int unsigned WW = 16;
  localparam int unsigned CW = 32;
  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 32'd1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [WW-1:0]   n_q, n_d;
  logic [WW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   com_data_in_q, com_data_in_d;
  logic [WW-1:0]   com_addr_q, com_addr_d;
  logic            com_wr_en_q, com_wr_en_d;
  logic            rx_ready_q, rx_ready_d;
  logic [1:0]      status_q, status_d;
  logic            busy_q, busy_d;
  logic            run_done_q, run_done_d;
  logic            err_len_q, err_len_d;
  logic            err_timeout_q, err_timeout_d;
  logic [CW-1:0]   run_cycles_q, run_cycles_d;
  logic            accept;

  assign accept = rx_valid & rx_ready_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    n_d           = n_q;
    idx_d         = idx_q;
    com_data_in_d = com_data_in_q;
    com_addr_d    = com_addr_q;
    com_wr_en_d   = 1'b0;
    run_done_d    = run_done_q;
    err_len_d     = err_len_q;
    err_timeout_d = err_timeout_q;
    run_cycles_d  = run_cycles_q;

    unique case (state_q)
      S_IDLE: state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d = {hi_q, rx_data};
          if ({1'b0, hi_q, rx_data} > MAX_WORDS) begin
            state_d   = S_ERR;
            err_len_d = 1'b1;
          end else if ({hi_q, rx_data} == 16'd0) begin
            state_d = S_RUN;
          end else begin
            state_d    = S_DAT_HI;
            idx_d      = '0;
            com_addr_d = BASE_ADDR;
          end
        end
      end
      S_DAT_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        // Address and data are registered here so they are stable during the strobe
        if (accept) begin
          com_data_in_d = {hi_q, rx_data};
          com_addr_d    = BASE_ADDR + idx_q;
          com_wr_en_d   = 1'b1;
          state_d       = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = ((17'(idx_q) + 17'd1) == 17'(n_q)) ? S_RUN : S_DAT_HI;
      end
      S_RUN: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
        if (end_process) begin
          state_d    = S_DONE;
          run_done_d = 1'b1;
        end else if ((TIMEOUT != 32'd0) && (run_cycles_q == TO_LAST)) begin
          state_d       = S_ERR;
          err_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase

    rx_ready_d = state_d inside {S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO};
    busy_d     = state_d inside {S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_RUN};
    status_d   = (state_d inside {S_RUN, S_DONE}) ? ST_RUN : ST_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hi_q          <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      com_data_in_q <= '0;
      com_addr_q    <= '0;
      com_wr_en_q   <= 1'b0;
      rx_ready_q    <= 1'b0;
      status_q      <= ST_LOAD;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      run_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      com_data_in_q <= com_data_in_d;
      com_addr_q    <= com_addr_d;
      com_wr_en_q   <= com_wr_en_d;
      rx_ready_q    <= rx_ready_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      run_cycles_q  <= run_cycles_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign com_data_in = com_data_in_q;
  assign com_addr    = com_addr_q;
  assign com_wr_en   = com_wr_en_q;
  assign status      = status_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign run_cycles  = run_cycles_q;

endmodule
